// File: rtl/sweep_pkg.sv
// Shared state type and default sizing for the up/down triangle-sweep controller.
package sweep_pkg;

    localparam int unsigned SWEEP_WIDTH = 4;
    localparam int unsigned SWEEP_NS_W  = 4;
    localparam int unsigned SWEEP_DWELL = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP   = 3'd1,
        ST_DOWN = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } sweep_state_e;

    function automatic logic state_is_busy(input sweep_state_e st);
        return (st == ST_UP) || (st == ST_DOWN) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/updown_core.sv
// WIDTH-bit up/down counter register with synchronous load and count enable.
module updown_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    // Counter register; load takes priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {WIDTH{1'b0}};
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= up ? (q + ONE_W) : (q - ONE_W);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep controller (lo -> hi -> lo, N times or until stop) driving updown_core.
// Optional turnaround dwell at hi/lo is enabled by defining SWEEP_DWELL_EN (DWELL must be >= 1).
module updown_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH = SWEEP_WIDTH,
    parameter int unsigned NS_W  = SWEEP_NS_W,
    parameter int unsigned DWELL = SWEEP_DWELL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NS_W-1:0]  n_sweeps,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    sweep_state_e     state_r, state_nxt_s;
    logic [WIDTH-1:0] lo_r, hi_r;
    logic [NS_W-1:0]  ns_r, cnt_r, cnt_nxt_s, cnt_inc_s;
    logic             dir_r, dir_nxt_s;
    logic             busy_r, done_r, err_r, err_nxt_s;
    logic             latch_s, load_s, en_s, up_s;
    logic [WIDTH-1:0] q_s;

`ifdef SWEEP_DWELL_EN
    localparam int unsigned   DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] DW_ONE     = {{(DW_W-1){1'b0}}, 1'b1};
    logic [DW_W-1:0] dwell_r, dwell_nxt_s;
`endif

    updown_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (lo),
        .en       (en_s),
        .up       (up_s),
        .q        (q_s)
    );

    // Sweep counter saturates so an endless run can never terminate by wrapping.
    assign cnt_inc_s = (cnt_r == {NS_W{1'b1}}) ? cnt_r : (cnt_r + {{(NS_W-1){1'b0}}, 1'b1});

    // Next-state, counter control and next-output decode.
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = 1'b0;
        latch_s     = 1'b0;
        load_s      = 1'b0;
        en_s        = 1'b0;
        up_s        = dir_r;
`ifdef SWEEP_DWELL_EN
        dwell_nxt_s = dwell_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    if (lo < hi) begin
                        latch_s     = 1'b1;
                        load_s      = 1'b1;
                        dir_nxt_s   = 1'b1;
                        cnt_nxt_s   = {NS_W{1'b0}};
                        state_nxt_s = ST_UP;
                    end else begin
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UP: begin
                if (stop) begin
                    cnt_nxt_s   = {NS_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else if (q_s == hi_r) begin
`ifdef SWEEP_DWELL_EN
                    dwell_nxt_s = DWELL_LAST;
                    state_nxt_s = ST_HOLD;
`else
                    en_s        = 1'b1;
                    up_s        = 1'b0;
                    dir_nxt_s   = 1'b0;
                    state_nxt_s = ST_DOWN;
`endif
                end else begin
                    en_s = 1'b1;
                    up_s = 1'b1;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    cnt_nxt_s   = {NS_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else if (q_s == lo_r) begin
                    cnt_nxt_s = cnt_inc_s;
                    if ((ns_r != {NS_W{1'b0}}) && (cnt_inc_s == ns_r)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        dwell_nxt_s = DWELL_LAST;
                        state_nxt_s = ST_HOLD;
`else
                        en_s        = 1'b1;
                        up_s        = 1'b1;
                        dir_nxt_s   = 1'b1;
                        state_nxt_s = ST_UP;
`endif
                    end
                end else begin
                    en_s = 1'b1;
                    up_s = 1'b0;
                end
            end
`ifdef SWEEP_DWELL_EN
            // dir still reflects the leg just finished, so it tells which way to turn.
            ST_HOLD: begin
                if (stop) begin
                    cnt_nxt_s   = {NS_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else if (dwell_r == {DW_W{1'b0}}) begin
                    en_s = 1'b1;
                    if (dir_r) begin
                        up_s        = 1'b0;
                        dir_nxt_s   = 1'b0;
                        state_nxt_s = ST_DOWN;
                    end else begin
                        up_s        = 1'b1;
                        dir_nxt_s   = 1'b1;
                        state_nxt_s = ST_UP;
                    end
                end else begin
                    dwell_nxt_s = dwell_r - DW_ONE;
                end
            end
`endif
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, bound/count latches and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            lo_r    <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            ns_r    <= {NS_W{1'b0}};
            cnt_r   <= {NS_W{1'b0}};
            dir_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dir_r   <= dir_nxt_s;
            busy_r  <= state_is_busy(state_nxt_s);
            done_r  <= (state_nxt_s == ST_DONE);
            err_r   <= err_nxt_s;
            if (latch_s) begin
                lo_r <= lo;
                hi_r <= hi;
                ns_r <= n_sweeps;
            end else begin
                lo_r <= lo_r;
                hi_r <= hi_r;
                ns_r <= ns_r;
            end
        end
    end

`ifdef SWEEP_DWELL_EN
    // Turnaround dwell counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_r <= {DW_W{1'b0}};
        end else begin
            dwell_r <= dwell_nxt_s;
        end
    end
`endif

    assign q    = q_s;
    assign dir  = dir_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule
